// File: rtl/instruction_fetch_pkg.sv
// Shared widths, reset PC, fetch-state encoding and fetch-queue payload
// for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int unsigned ADDRESS_WIDTH = 32;
    localparam int unsigned WORD_WIDTH    = 32;
    localparam int unsigned FQ_DEPTH      = 2;
    localparam int unsigned FQ_COUNT_W    = 2;

    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(32'h0000_1000);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0]    instr;
    } fq_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDRESS_WIDTH-1:0] word_align(input logic [ADDRESS_WIDTH-1:0] addr);
        return addr & ~ADDRESS_WIDTH'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_fetch_queue.sv
// Two-entry {pc, instr} circular buffer between fetch and decode; flush
// wins over push/pop, and a push into a full queue is allowed only with a pop.
module fetch_queue
    import instruction_fetch_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  fq_entry_t push_entry,
    input  logic      pop,
    input  logic      flush,
    output fq_entry_t head_entry,
    output logic      valid,
    output logic      full
);

    fq_entry_t               entries [FQ_DEPTH];
    logic                    head;
    logic [FQ_COUNT_W-1:0]   count;
    logic                    tail_c;
    logic                    do_pop_c;
    logic                    do_push_c;

    // Tail is head+count modulo 2; with count==2 it aliases head, which is
    // the slot freed by the simultaneous pop.
    always_comb begin
        tail_c    = head ^ count[0];
        do_pop_c  = pop && (count != '0);
        do_push_c = push && ((count != FQ_COUNT_W'(FQ_DEPTH)) || do_pop_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= 1'b0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (do_push_c) begin
                entries[tail_c] <= push_entry;
            end
            if (do_pop_c) begin
                head <= ~head;
            end
            count <= count + FQ_COUNT_W'(do_push_c) - FQ_COUNT_W'(do_pop_c);
        end
    end

    assign head_entry = entries[head];
    assign valid      = (count != '0);
    assign full       = (count == FQ_COUNT_W'(FQ_DEPTH));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the ICache address, and holds the address
// across a redirect until the outstanding response arrives and is discarded.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] icache_address,
    output logic                     icache_byte_op,
    input  logic [WORD_WIDTH-1:0]    icache_data_in,
    input  logic                     icache_data_ready,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     decode_ready,
    output logic                     instr_valid,
    output logic [WORD_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     fetch_stalled
);

    fetch_state_t             state;
    fetch_state_t             state_next;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [ADDRESS_WIDTH-1:0] pending_pc;
    logic [ADDRESS_WIDTH-1:0] pending_next;
    logic [ADDRESS_WIDTH-1:0] target_c;
    logic                     stall_c;
    logic                     push_c;
    logic                     pop_c;
    logic                     flush_c;
    logic                     fq_full;
    fq_entry_t                push_entry_c;
    fq_entry_t                head_entry;

    assign target_c     = word_align(redirect_pc);
    assign push_entry_c = '{pc: pc, instr: icache_data_in};

    // A redirect flushes the queue, so a same-cycle pop is meaningless.
    assign pop_c = instr_valid && decode_ready && !redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            pending_pc    <= RESET_PC;
            fetch_stalled <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            pending_pc    <= pending_next;
            fetch_stalled <= stall_c;
        end
    end

    // PC only moves on a response edge, so the ICache address is stable
    // throughout a miss.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pending_next = pending_pc;
        stall_c      = 1'b0;
        push_c       = 1'b0;
        flush_c      = 1'b0;

        unique case (state)
            FETCH: begin
                if (redirect_valid) begin
                    flush_c = 1'b1;
                    if (icache_data_ready) begin
                        pc_next = target_c;
                    end else begin
                        pending_next = target_c;
                        state_next   = DRAIN;
                    end
                end else if (icache_data_ready) begin
                    if (!fq_full || pop_c) begin
                        push_c  = 1'b1;
                        pc_next = pc + ADDRESS_WIDTH'(4);
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    flush_c      = 1'b1;
                    pending_next = target_c;
                    if (icache_data_ready) begin
                        pc_next    = target_c;
                        state_next = FETCH;
                    end
                end else if (icache_data_ready) begin
                    pc_next    = pending_pc;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    fetch_queue u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push_c),
        .push_entry (push_entry_c),
        .pop        (pop_c),
        .flush      (flush_c),
        .head_entry (head_entry),
        .valid      (instr_valid),
        .full       (fq_full)
    );

    assign icache_address = pc;
    assign icache_byte_op = 1'b0;
    assign instr          = head_entry.instr;
    assign instr_pc       = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a queue-based
// reference model of the fetch rules.
module tb_instruction_fetch;

    localparam logic [31:0] K      = 32'hA5A5_A5A5;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic [31:0] icache_address;
    logic        icache_byte_op;
    logic [31:0] icache_data_in;
    logic        icache_data_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        decode_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_stalled;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_target;
    logic        m_discard;
    logic        m_stall;

    instruction_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .icache_address    (icache_address),
        .icache_byte_op    (icache_byte_op),
        .icache_data_in    (icache_data_in),
        .icache_data_ready (icache_data_ready),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .decode_ready      (decode_ready),
        .instr_valid       (instr_valid),
        .instr             (instr),
        .instr_pc          (instr_pc),
        .fetch_stalled     (fetch_stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, observed running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = RST_PC;
        m_target  = RST_PC;
        m_discard = 1'b0;
        m_stall   = 1'b0;
    endtask

    // One clock of the fetch rules: a redirect either retargets at once (if the
    // response is here) or marks the next response for discard.
    task automatic model_update(input logic dr, input logic rv, input logic [31:0] rpc, input logic dec);
        logic pop;
        pop     = (mq.size() != 0) && dec && !rv;
        m_stall = 1'b0;
        if (rv) begin
            mq.delete();
            if (dr) begin
                m_pc      = rpc & ~32'd3;
                m_discard = 1'b0;
            end else begin
                m_target  = rpc & ~32'd3;
                m_discard = 1'b1;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (dr) begin
                if (m_discard) begin
                    m_pc      = m_target;
                    m_discard = 1'b0;
                end else if (mq.size() < 2) begin
                    mq.push_back('{pc: m_pc, word: m_pc ^ K});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_stall = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("icache_address", icache_address, m_pc);
        chk("icache_byte_op", 32'(icache_byte_op), 32'd0);
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("instr_pc", instr_pc, mq[0].pc);
            chk("instr", instr, mq[0].word);
        end
        chk("fetch_stalled", 32'(fetch_stalled), 32'(m_stall));
    endtask

    task automatic step(input logic dr, input logic rv, input logic [31:0] rpc, input logic dec);
        @(negedge clk);
        icache_data_ready = dr;
        icache_data_in    = icache_address ^ K;
        redirect_valid    = rv;
        redirect_pc       = rpc;
        decode_ready      = dec;
        @(posedge clk);
        model_update(dr, rv, rpc, dec);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset             = 1'b1;
        icache_data_ready = 1'b0;
        icache_data_in    = '0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        decode_ready      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();
        chk("reset_instr", instr, 32'd0);
        chk("reset_instr_pc", instr_pc, 32'd0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b1;
        icache_data_ready = 1'b0;
        icache_data_in    = '0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        decode_ready      = 1'b0;
        model_reset();

        // Sequential hits with decode always ready.
        do_reset();
        step(1, 0, 0, 1);
        chk("t1_pc0", instr_pc, 32'h1000);
        chk("t1_w0", instr, 32'hA5A5_B5A5);
        step(1, 0, 0, 1);
        chk("t1_pc1", instr_pc, 32'h1004);
        chk("t1_w1", instr, 32'hA5A5_B5A1);
        step(1, 0, 0, 1);
        chk("t1_pc2", instr_pc, 32'h1008);
        chk("t1_w2", instr, 32'hA5A5_B5AD);

        // Decode stalled: queue fills, further responses are dropped.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t2_addr_stuck", icache_address, 32'h1008);
        chk("t2_stall", 32'(fetch_stalled), 32'd1);
        step(1, 0, 0, 0);
        chk("t2_stall2", 32'(fetch_stalled), 32'd1);
        step(0, 0, 0, 1);
        chk("t2_head0", instr_pc, 32'h1004);
        step(1, 0, 0, 1);
        chk("t2_head1", instr_pc, 32'h1008);

        // Redirect during a long miss: address held, response discarded.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h2000, 0);
        chk("t3_flush", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 1);
            chk("t3_hold", icache_address, 32'h1004);
        end
        step(1, 0, 0, 1);
        chk("t3_new_addr", icache_address, 32'h2000);
        chk("t3_dropped", 32'(instr_valid), 32'd0);
        step(1, 0, 0, 1);
        chk("t3_first_pc", instr_pc, 32'h2000);

        // Redirect with response, then a double redirect through DRAIN.
        do_reset();
        step(1, 1, 32'h2003, 1);
        chk("t4_aligned", icache_address, 32'h2000);
        step(0, 1, 32'h2100, 1);
        step(0, 1, 32'h3000, 1);
        step(1, 0, 0, 1);
        chk("t4_newest", icache_address, 32'h3000);
        step(1, 0, 0, 1);
        chk("t4_first_pc", instr_pc, 32'h3000);

        // Asynchronous reset between edges while draining.
        step(0, 1, 32'h4000, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_addr", icache_address, RST_PC);
        chk("t5_async_valid", 32'(instr_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset             = 1'b0;
        icache_data_ready = 1'b0;
        redirect_valid    = 1'b0;
        step(1, 0, 0, 1);
        chk("t5_fetch_after", instr_pc, RST_PC);

        // PC wraps modulo 2^32.
        step(1, 1, 32'hFFFF_FFFC, 1);
        step(1, 0, 0, 1);
        chk("t6_top", instr_pc, 32'hFFFF_FFFC);
        step(1, 0, 0, 1);
        chk("t6_wrap", instr_pc, 32'h0000_0000);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic        dr;
            logic        rv;
            logic        dec;
            logic [31:0] rpc;
            dr  = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            dec = ($urandom_range(0, 2) != 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(dr, rv, rpc, dec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
